// File: rtl/axi4lite_led_sequencer.sv
// axi4lite_led_sequencer: every PERIOD cycles writes the next LED pattern over AXI4-Lite, reads it back and checks it
module axi4lite_led_sequencer #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int LED_WIDTH = 8,
  parameter int PERIOD = 50000000,
  parameter logic [ADDR_WIDTH-1:0] LED_ADDR = '0,
  parameter logic [LED_WIDTH-1:0] INIT_PATTERN = LED_WIDTH'(1)
) (
  input  logic                    m_axi_aclk,
  input  logic                    m_axi_areset,
  output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic                    m_axi_awvalid,
  input  logic                    m_axi_awready,
  output logic [DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                    m_axi_wvalid,
  input  logic                    m_axi_wready,
  input  logic [1:0]              m_axi_bresp,
  input  logic                    m_axi_bvalid,
  output logic                    m_axi_bready,
  output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
  output logic                    m_axi_arvalid,
  input  logic                    m_axi_arready,
  input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
  input  logic [1:0]              m_axi_rresp,
  input  logic                    m_axi_rvalid,
  output logic                    m_axi_rready,
  input  logic                    enable,
  input  logic [1:0]              mode,
  output logic [LED_WIDTH-1:0]    pattern,
  output logic                    busy,
  output logic                    mismatch,
  output logic                    bus_error,
  output logic                    tick_missed
);
  localparam int TW = $clog2(PERIOD);
  typedef enum logic [2:0] {IDLE, WRITE, WRESP, READ, RDATA, CHECK} state_t;
  state_t state, state_n;
  logic [TW-1:0] timer;
  logic [LED_WIDTH-1:0] rdata_q, shifted, next_pattern;
  logic tick, pending, start, aw_hs, w_hs, aw_done, w_done, dir, flip, unused_rdata;
  assign tick = enable && timer == TW'(PERIOD - 1);
  assign start = state == IDLE && pending && enable;
  assign aw_hs = m_axi_awvalid && m_axi_awready;
  assign w_hs = m_axi_wvalid && m_axi_wready;
  assign m_axi_awaddr = LED_ADDR;
  assign m_axi_araddr = LED_ADDR;
  assign m_axi_wstrb = '1;
  assign unused_rdata = ^m_axi_rdata;
  // dir = 0 moves the bounce toward the MSB, 1 toward the LSB
  assign shifted = dir ? pattern >> 1 : pattern << 1;
  assign flip = mode == 2'd3 && pattern != '0 && (dir ? shifted[0] : shifted[LED_WIDTH-1]);
  always_comb begin
    next_pattern = pattern;
    case (mode)
      2'd0: next_pattern = {pattern[LED_WIDTH-2:0], pattern[LED_WIDTH-1]};
      2'd1: next_pattern = {pattern[0], pattern[LED_WIDTH-1:1]};
      2'd2: next_pattern = pattern + LED_WIDTH'(1);
      default: next_pattern = pattern == '0 ? LED_WIDTH'(1) : shifted;
    endcase
  end
  always_comb begin
    state_n = state;
    case (state)
      IDLE: state_n = start ? WRITE : IDLE;
      WRITE: state_n = (aw_done || aw_hs) && (w_done || w_hs) ? WRESP : WRITE;
      WRESP: state_n = m_axi_bvalid && m_axi_bready ? READ : WRESP;
      READ: state_n = m_axi_arvalid && m_axi_arready ? RDATA : READ;
      RDATA: state_n = m_axi_rvalid && m_axi_rready ? CHECK : RDATA;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge m_axi_aclk) begin
    if (m_axi_areset) state <= IDLE;
    else state <= state_n;
  end
  always_ff @(posedge m_axi_aclk) begin
    if (m_axi_areset) begin
      timer <= '0;
      pending <= 1'b0;
      tick_missed <= 1'b0;
      m_axi_awvalid <= 1'b0;
      m_axi_wvalid <= 1'b0;
      m_axi_bready <= 1'b0;
      m_axi_arvalid <= 1'b0;
      m_axi_rready <= 1'b0;
      m_axi_wdata <= '0;
      pattern <= INIT_PATTERN;
      dir <= 1'b0;
      busy <= 1'b0;
      mismatch <= 1'b0;
      bus_error <= 1'b0;
      aw_done <= 1'b0;
      w_done <= 1'b0;
      rdata_q <= '0;
    end else begin
      timer <= !enable || tick ? '0 : timer + TW'(1);
      pending <= enable && (tick || (pending && !start));
      if (tick && pending && !start) tick_missed <= 1'b1;
      case (state)
        IDLE: if (start) begin
          m_axi_awvalid <= 1'b1;
          m_axi_wvalid <= 1'b1;
          m_axi_wdata <= DATA_WIDTH'(pattern);
          busy <= 1'b1;
          aw_done <= 1'b0;
          w_done <= 1'b0;
        end
        WRITE: begin
          if (aw_hs) begin
            m_axi_awvalid <= 1'b0;
            aw_done <= 1'b1;
          end
          if (w_hs) begin
            m_axi_wvalid <= 1'b0;
            w_done <= 1'b1;
          end
          if (state_n == WRESP) m_axi_bready <= 1'b1;
        end
        WRESP: if (m_axi_bvalid) begin
          m_axi_bready <= 1'b0;
          m_axi_arvalid <= 1'b1;
          if (m_axi_bresp != 2'b00) bus_error <= 1'b1;
        end
        READ: if (m_axi_arready) begin
          m_axi_arvalid <= 1'b0;
          m_axi_rready <= 1'b1;
        end
        RDATA: if (m_axi_rvalid) begin
          m_axi_rready <= 1'b0;
          rdata_q <= m_axi_rdata[LED_WIDTH-1:0];
          if (m_axi_rresp != 2'b00) bus_error <= 1'b1;
        end
        CHECK: begin
          if (rdata_q != pattern) mismatch <= 1'b1;
          pattern <= next_pattern;
          if (flip) dir <= !dir;
          busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_axi4lite_led_sequencer.sv
// tb_axi4lite_led_sequencer: randomized AXI4-Lite LED slave with a scoreboard of expected write data
module tb_axi4lite_led_sequencer;
  localparam int P = 20;
  logic clk = 0;
  logic m_axi_areset = 1;
  logic [31:0] m_axi_awaddr, m_axi_wdata, m_axi_araddr;
  logic [31:0] m_axi_rdata = 0;
  logic [3:0] m_axi_wstrb;
  logic m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready;
  logic m_axi_awready = 0, m_axi_wready = 0, m_axi_bvalid = 0, m_axi_arready = 0, m_axi_rvalid = 0;
  logic [1:0] m_axi_bresp = 0, m_axi_rresp = 0;
  logic enable = 0;
  logic [1:0] mode = 0;
  logic [7:0] pattern;
  logic busy, mismatch, bus_error, tick_missed;
  axi4lite_led_sequencer #(.PERIOD(P)) dut (
    .m_axi_aclk(clk), .m_axi_areset(m_axi_areset),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
    .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
    .enable(enable), .mode(mode), .pattern(pattern), .busy(busy),
    .mismatch(mismatch), .bus_error(bus_error), .tick_missed(tick_missed)
  );
  always #5 clk = ~clk;
  int vectors = 0, errors = 0;
  logic [7:0] exp_q[$];
  logic [31:0] obs_q[$];
  logic [31:0] obs_d;
  logic [7:0] led = 0;
  logic [31:0] wdata_prev = 0;
  bit aw_got, w_got, ar_got, aw_pend, w_pend, directed;
  int aw_wait, w_wait, b_wait, ar_wait, r_wait, txn, r_idx, wr_cnt;
  int stall_txn = -1, stall_len = 0, inj_txn = -1;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    vectors++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, got, want);
    end
  endtask

  // k-th pattern written after reset (INIT = 01), straight from the mode definitions
  function automatic logic [7:0] model(input int m, input int k);
    int pos;
    pos = k % 14;
    case (m)
      0: return 8'(1 << (k % 8));
      1: return 8'(1 << ((8 - k % 8) % 8));
      2: return 8'((k + 1) % 256);
      default: return 8'(1 << (pos < 8 ? pos : 14 - pos));
    endcase
  endfunction

  task automatic pick();
    aw_wait = $urandom_range(0, 2);
    w_wait = $urandom_range(0, 2);
    if (directed && txn == 0) begin aw_wait = 0; w_wait = 3; end
    else if (directed && txn == 1) begin aw_wait = 3; w_wait = 0; end
    else if (directed && txn == 2) begin aw_wait = 0; w_wait = 0; end
    b_wait = txn == stall_txn ? stall_len : $urandom_range(0, 2);
    ar_wait = $urandom_range(0, 1);
    r_wait = $urandom_range(0, 2);
  endtask

  // slave: decides ready/valid at negedge, the handshake lands on the following posedge
  always @(negedge clk) begin
    if (m_axi_areset) begin
      {m_axi_awready, m_axi_wready, m_axi_bvalid, m_axi_arready, m_axi_rvalid} = '0;
      {aw_got, w_got, ar_got, aw_pend, w_pend} = '0;
      txn = 0; r_idx = 0; wr_cnt = 0; led = 0;
      obs_q.delete();
      pick();
    end else begin
      if (aw_pend) chk("awvalid_held", m_axi_awvalid, 1);
      if (w_pend) begin
        chk("wvalid_held", m_axi_wvalid, 1);
        chk("wdata_stable", m_axi_wdata, wdata_prev);
      end
      if (aw_got) chk("no_extra_awvalid", m_axi_awvalid, 0);
      if (w_got) chk("no_extra_wvalid", m_axi_wvalid, 0);
      if (m_axi_bready) chk("bready_after_aw_w", {aw_got, w_got}, 2'b11);
      m_axi_bvalid = aw_got && w_got && b_wait == 0;
      if (aw_got && w_got && b_wait > 0) b_wait--;
      m_axi_bresp = txn == inj_txn ? 2'b10 : 2'b00;
      if (m_axi_bvalid && m_axi_bready) begin
        aw_got = 0; w_got = 0; txn++;
        pick();
      end
      m_axi_awready = m_axi_awvalid && !aw_got && aw_wait == 0;
      if (m_axi_awvalid && !aw_got && aw_wait > 0) aw_wait--;
      if (m_axi_awvalid && m_axi_awready) begin
        aw_got = 1;
        chk("awaddr", m_axi_awaddr, 0);
      end
      m_axi_wready = m_axi_wvalid && !w_got && w_wait == 0;
      if (m_axi_wvalid && !w_got && w_wait > 0) w_wait--;
      if (m_axi_wvalid && m_axi_wready) begin
        w_got = 1; led = m_axi_wdata[7:0]; wr_cnt++;
        obs_q.push_back(m_axi_wdata);
      end
      m_axi_rvalid = ar_got && r_wait == 0;
      if (ar_got && r_wait > 0) r_wait--;
      m_axi_rdata = r_idx == inj_txn ? 32'd0 : {24'd0, led};
      if (m_axi_rvalid && m_axi_rready) begin ar_got = 0; r_idx++; end
      m_axi_arready = m_axi_arvalid && !ar_got && ar_wait == 0;
      if (m_axi_arvalid && !ar_got && ar_wait > 0) ar_wait--;
      if (m_axi_arvalid && m_axi_arready) begin
        ar_got = 1;
        chk("araddr", m_axi_araddr, 0);
      end
      aw_pend = m_axi_awvalid && !m_axi_awready;
      w_pend = m_axi_wvalid && !m_axi_wready;
      wdata_prev = m_axi_wdata;
    end
  end

  always @(posedge clk) begin
    while (obs_q.size() > 0) begin
      obs_d = obs_q.pop_front();
      if (exp_q.size() == 0) begin
        vectors++; errors++;
        $display("FAIL unexpected_write: got %0h, no write expected", obs_d);
      end else chk("wdata", obs_d, {24'd0, exp_q.pop_front()});
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic check_reset();
    chk("rst_valids", {m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready}, 0);
    chk("rst_status", {busy, mismatch, bus_error, tick_missed}, 0);
    chk("rst_pattern", pattern, 8'h01);
    chk("rst_wdata", m_axi_wdata, 0);
    chk("rst_wstrb", m_axi_wstrb, 4'hF);
    chk("rst_addr", {m_axi_awaddr, m_axi_araddr}, 0);
  endtask

  task automatic do_reset();
    m_axi_areset = 1; enable = 0;
    exp_q.delete();
    cyc(2);
    m_axi_areset = 0;
  endtask

  // flags = {mismatch, bus_error, tick_missed} expected at the end of the phase
  task automatic run_phase(input int m, input int n, input logic [2:0] flags);
    do_reset();
    mode = 2'(m); enable = 1;
    for (int k = 0; k < n; k++) exp_q.push_back(model(m, k));
    for (int i = 0; i < n * P * 2 + 400 && wr_cnt < n; i++) cyc();
    chk("phase_writes", wr_cnt, n);
    enable = 0;
    for (int i = 0; i < 200 && busy; i++) cyc();
    cyc(2 * P);
    chk("phase_drained", exp_q.size(), 0);
    chk("phase_flags", {mismatch, bus_error, tick_missed}, flags);
    chk("led_register", led, model(m, n - 1));
  endtask

  initial begin
    cyc(2);
    check_reset();
    directed = 1; inj_txn = 2;
    run_phase(0, 10, 3'b110);
    directed = 0; inj_txn = -1;
    run_phase(1, 10, 3'b000);
    run_phase(3, 16, 3'b000);
    run_phase(2, 258, 3'b000);
    stall_txn = 1; stall_len = 60;
    run_phase(0, 6, 3'b001);
    stall_txn = 0; stall_len = 200;
    do_reset();
    enable = 1;
    exp_q.push_back(model(0, 0));
    for (int i = 0; i < 3 * P && !m_axi_bready; i++) cyc();
    chk("reached_wresp", m_axi_bready, 1);
    m_axi_areset = 1;
    cyc();
    check_reset();
    stall_txn = -1;
    do_reset();
    mode = 2'($urandom_range(0, 3));
    enable = 1;
    exp_q.push_back(model(mode, 0));
    for (int i = 0; i < 3 * P && !m_axi_arvalid; i++) cyc();
    chk("reached_read", m_axi_arvalid, 1);
    enable = 0;
    for (int i = 0; i < 100 && busy; i++) cyc();
    chk("drop_txn_finished", busy, 0);
    cyc(4 * P);
    chk("drop_no_more_writes", wr_cnt, 1);
    chk("drop_drained", exp_q.size(), 0);
    chk("drop_idle", {busy, m_axi_awvalid, m_axi_wvalid}, 0);
    chk("drop_pattern_advanced", pattern, model(mode, 1));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, vectors %0d", vectors);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/axi4lite_led_sequencer.md
Name: axi4lite_led_sequencer

Overview:
- AXI4-Lite master that drives the LED controller slave: every PERIOD cycles it writes the next LED pattern to LED_ADDR, reads it back and checks it.
- Sits between the system timebase and the LED controller's AXI4-Lite slave port. It is the only master on that port.
- Supports four pattern modes and reports status: busy, readback mismatch, bus error, missed tick.

Parameters:
- DATA_WIDTH, 32, AXI data width (multiple of 8, at least LED_WIDTH).
- ADDR_WIDTH, 32, AXI address width.
- LED_WIDTH, 8, pattern width (at least 2).
- PERIOD, 50000000, cycles between pattern updates (at least 8).
- LED_ADDR, 0, byte address of the LED register.
- INIT_PATTERN, 1, pattern value after reset (LED_WIDTH bits).

Ports:
- m_axi_aclk  in  1  clock
- m_axi_areset  in  1  synchronous reset, active-high
- m_axi_awaddr  out  ADDR_WIDTH  write address
- m_axi_awvalid  out  1  write address valid
- m_axi_awready  in  1  write address ready
- m_axi_wdata  out  DATA_WIDTH  write data
- m_axi_wstrb  out  DATA_WIDTH/8  write strobes
- m_axi_wvalid  out  1  write data valid
- m_axi_wready  in  1  write data ready
- m_axi_bresp  in  2  write response
- m_axi_bvalid  in  1  write response valid
- m_axi_bready  out  1  write response ready
- m_axi_araddr  out  ADDR_WIDTH  read address
- m_axi_arvalid  out  1  read address valid
- m_axi_arready  in  1  read address ready
- m_axi_rdata  in  DATA_WIDTH  read data
- m_axi_rresp  in  2  read response
- m_axi_rvalid  in  1  read data valid
- m_axi_rready  out  1  read data ready
- enable  in  1  run the sequencer
- mode  in  2  pattern mode: 0 rotate left, 1 rotate right, 2 increment, 3 bounce
- pattern  out  LED_WIDTH  current pattern (the value written by the next or current transaction)
- busy  out  1  transaction in progress
- mismatch  out  1  sticky: readback differed from written value
- bus_error  out  1  sticky: bresp or rresp was not OKAY
- tick_missed  out  1  sticky: a tick arrived while a tick was already pending

Behaviour:
- Reset values: all valid/ready outputs 0; awaddr = araddr = LED_ADDR; wdata = 0; wstrb = all ones; pattern = INIT_PATTERN; busy, mismatch, bus_error, tick_missed = 0; timer = 0; state = IDLE; bounce direction = left. Sticky flags clear only on reset.
- Reset asserted mid-transaction: all state and outputs return to reset values on the next edge; the transaction is abandoned.
- Timer: counts 0..PERIOD-1 while enable = 1 and wraps; tick = 1 for one cycle when the count is PERIOD-1. When enable = 0 the timer holds at 0.
- Pending tick: one-deep. Set by tick, cleared when the transaction starts. A tick while pending is already 1 sets tick_missed.
- First tick occurs PERIOD cycles after enable rises.
- FSM states: IDLE, WRITE, WRESP, READ, RDATA, CHECK.
- IDLE → WRITE when pending = 1 and enable = 1. On entry: awvalid = wvalid = 1, wdata = zero-extended pattern, busy = 1.
- WRITE: awvalid drops the cycle after the aw handshake; wvalid drops the cycle after the w handshake; each handshake is tracked independently, so either order or both in the same cycle is legal. Once both are done: bready = 1, go to WRESP.
- Valid stability: awvalid/wvalid never deassert before their handshake; address and data stay stable while valid.
- WRESP: on bvalid & bready, bready = 0; bresp ≠ 0 sets bus_error. Then arvalid = 1, go to READ.
- READ: on arready, arvalid = 0 and rready = 1, go to RDATA.
- RDATA: on rvalid, rready = 0; capture rdata[LED_WIDTH-1:0] and rresp; rresp ≠ 0 sets bus_error. Go to CHECK.
- CHECK (one cycle): captured value ≠ pattern sets mismatch. The pattern advances regardless of mismatch. busy = 0, go to IDLE.
- Pattern advance:
  - rotate left / rotate right by 1.
  - increment modulo 2^LED_WIDTH.
  - bounce: shift in the current direction; when the next value would have bit LED_WIDTH-1 (left) or bit 0 (right) set, flip direction. If pattern = 0 in bounce mode, load 1.
- mode is sampled only in CHECK; a change mid-transaction takes effect at the next advance.
- enable falling mid-transaction: the transaction completes, then the FSM stays in IDLE. pending is cleared while enable = 0.
- No timeout: the FSM waits indefinitely on slave handshakes.
- Minimum transaction with the LED controller: about 8 cycles, well below PERIOD.

Test Plan:
- PERIOD=8, INIT=8'h01, mode 0, enable → writes 01, 02, 04 … 80, 01 at 8-cycle spacing; LED slave leds track; mismatch = bus_error = 0.
- mode 3, INIT=8'h01 → sequence 01, 02 … 80, 40 … 01, 02; mode 2 from 8'hFF → wraps to 00.
- Slave model: awready 3 cycles before wready, then wready before awready, then both together → exactly one write each time, valids held until handshake, bready asserted only after both handshakes.
- Slave returns bresp = 2'b10, then rdata = 8'h00 for a written 8'h04 → bus_error = 1 and mismatch = 1, sequencing continues with 8'h08.
- Stall bvalid for 20 cycles with PERIOD=8 → tick_missed = 1; only one queued transaction follows.
- Assert areset while in WRESP, and drop enable while in READ → respectively all outputs at reset values next cycle; transaction finishes, then the FSM stays in IDLE with no further writes.
